// File: rtl/turf_rate_monitor.sv
// turf_rate_monitor
// Multi-channel event-rate counter. Each channel counts single-cycle event
// pulses over a programmable gate interval. At the end of the interval the
// per-channel totals and overflow flags are latched together and announced
// with a one-cycle update pulse. Intervals run continuously or one at a time.
//
// Configuration macro:
//   TURF_RATE_MONITOR_SATURATE_EN  defined   -> accumulators saturate at all-ones
//                                  undefined -> accumulators wrap (default)
// The overflow flag behaves the same way in both builds.

module turf_rate_monitor #(
    parameter int NCH        = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int GATE_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NCH-1:0]            evt_i,
    input  logic [GATE_WIDTH-1:0]     gate_len_i,
    input  logic                      run_i,
    input  logic                      oneshot_i,
    output logic [NCH*CNT_WIDTH-1:0]  count_o,
    output logic [NCH-1:0]            ovf_o,
    output logic                      update_o,
    output logic                      valid_o,
    output logic                      busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]               state_q;
    logic [GATE_WIDTH-1:0]    gate_q;
    logic [NCH*CNT_WIDTH-1:0] acc_q;
    logic [NCH*CNT_WIDTH-1:0] acc_nxt;
    logic [NCH-1:0]           ovf_q;
    logic [NCH-1:0]           ovf_nxt;
    logic                     terminal;

    // The terminal cycle is the last cycle of the interval; its own events
    // still belong to the interval being latched.
    assign terminal = (gate_q == '0);
    assign busy_o   = (state_q == ST_RUN);

    // Per-channel accumulator and overflow flag after this cycle's events.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        acc_nxt = acc_q;
        ovf_nxt = ovf_q;
        for (int n = 0; n < NCH; n++) begin
            if (evt_i[n]) begin
                if (acc_q[n*CNT_WIDTH +: CNT_WIDTH] == CNT_MAX) begin
                    ovf_nxt[n] = 1'b1;
`ifdef TURF_RATE_MONITOR_SATURATE_EN
                    acc_nxt[n*CNT_WIDTH +: CNT_WIDTH] = CNT_MAX;
`else
                    acc_nxt[n*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
                end else begin
                    acc_nxt[n*CNT_WIDTH +: CNT_WIDTH] =
                        acc_q[n*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Interval control, accumulation and result latching.
    always_ff @(posedge clk_i) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gate_q   <= '0;
            acc_q    <= '0;
            ovf_q    <= '0;
            count_o  <= '0;
            ovf_o    <= '0;
            update_o <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            update_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run_i) begin
                        state_q <= ST_RUN;
                        gate_q  <= gate_len_i;
                        acc_q   <= '0;
                        ovf_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!run_i) begin
                        // Abort takes priority, even on the terminal cycle.
                        state_q <= ST_IDLE;
                        acc_q   <= '0;
                        ovf_q   <= '0;
                    end else if (terminal) begin
                        count_o  <= acc_nxt;
                        ovf_o    <= ovf_nxt;
                        update_o <= 1'b1;
                        valid_o  <= 1'b1;
                        acc_q    <= '0;
                        ovf_q    <= '0;
                        // Reload unconditionally: harmless in one-shot mode and
                        // gives continuous mode back-to-back intervals.
                        gate_q   <= gate_len_i;
                        if (oneshot_i) begin
                            state_q <= ST_DONE;
                        end
                    end else begin
                        gate_q <= gate_q - GATE_WIDTH'(1);
                        acc_q  <= acc_nxt;
                        ovf_q  <= ovf_nxt;
                    end
                end
                ST_DONE: begin
                    if (!run_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turf_rate_monitor.sv
// tb_turf_rate_monitor
// Self-checking bench for turf_rate_monitor (NCH=4, CNT_WIDTH=8). The
// reference model keeps plain integer event totals per interval and derives
// the latched value and overflow flag from them when the interval ends.
// Honours TURF_RATE_MONITOR_SATURATE_EN the same way the design does.

module tb_turf_rate_monitor;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int GW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NCH-1:0]    evt_i;
    logic [GW-1:0]     gate_len_i;
    logic              run_i;
    logic              oneshot_i;
    logic [NCH*CW-1:0] count_o;
    logic [NCH-1:0]    ovf_o;
    logic              update_o;
    logic              valid_o;
    logic              busy_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int                m_sum [NCH];
    int                m_left;
    bit                m_run;
    bit                m_done;
    logic [NCH*CW-1:0] m_count;
    logic [NCH-1:0]    m_ovf;
    bit                m_update;
    bit                m_valid;

    turf_rate_monitor #(.NCH(NCH), .CNT_WIDTH(CW), .GATE_WIDTH(GW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .evt_i      (evt_i),
        .gate_len_i (gate_len_i),
        .run_i      (run_i),
        .oneshot_i  (oneshot_i),
        .count_o    (count_o),
        .ovf_o      (ovf_o),
        .update_o   (update_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int latched_value(int total);
`ifdef TURF_RATE_MONITOR_SATURATE_EN
        return (total > CMAX) ? CMAX : total;
`else
        return total % (CMAX + 1);
`endif
    endfunction

    function automatic logic [38:0] dut_vec();
        return {update_o, valid_o, busy_o, ovf_o, count_o};
    endfunction

    function automatic logic [38:0] exp_vec();
        return {m_update, m_valid, m_run, m_ovf, m_count};
    endfunction

    // Advances the model by one clock edge using the inputs present at the edge.
    task automatic model_step();
        m_update = 1'b0;
        if (rst_i) begin
            m_run = 0; m_done = 0; m_valid = 0; m_left = 0;
            m_count = '0; m_ovf = '0;
            foreach (m_sum[n]) m_sum[n] = 0;
        end else if (m_run) begin
            if (!run_i) begin
                m_run = 0;
            end else begin
                foreach (m_sum[n]) m_sum[n] += int'(evt_i[n]);
                m_left--;
                if (m_left == 0) begin
                    foreach (m_sum[n]) begin
                        m_count[n*CW +: CW] = CW'(latched_value(m_sum[n]));
                        m_ovf[n]            = (m_sum[n] > CMAX);
                    end
                    m_update = 1'b1;
                    m_valid  = 1'b1;
                    if (oneshot_i) begin
                        m_run = 0; m_done = 1;
                    end else begin
                        m_left = int'(gate_len_i) + 1;
                        foreach (m_sum[n]) m_sum[n] = 0;
                    end
                end
            end
        end else if (m_done) begin
            if (!run_i) m_done = 0;
        end else if (run_i) begin
            m_run  = 1;
            m_left = int'(gate_len_i) + 1;
            foreach (m_sum[n]) m_sum[n] = 0;
        end
    endtask

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; run_i = 1'b0; evt_i = '0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (dut_vec() !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=0", dut_vec());
        end
        gate_len_i = 16'd9; oneshot_i = 1'b0; run_i = 1'b1;
        step();
        for (int k = 0; k < 25; k++) begin
            evt_i = NCH'($urandom);
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_pre cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_valid_before got=%b want=1", valid_o);
        end
        rst_i = 1'b1;
        step();
        vectors++;
        if (dut_vec() !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_mid got=%h want=0", dut_vec());
        end
        rst_i = 1'b0;
        step();
        vectors++;
        if (busy_o !== 1'b1 || update_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_to_idle busy=%b upd=%b want busy=1 upd=0", busy_o, update_o);
        end
    endtask

    task automatic test_continuous();
        logic [NCH*CW-1:0] want;
        want = {8'd1, 8'd0, 8'd25, 8'd100};
        do_reset();
        gate_len_i = 16'd99; oneshot_i = 1'b0; run_i = 1'b1;
        step();
        for (int k = 0; k < 300; k++) begin
            evt_i[0] = 1'b1;
            evt_i[1] = ((k % 100) % 4 == 0);
            evt_i[2] = 1'b0;
            evt_i[3] = ((k % 100) == 99);
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL continuous cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            if ((k % 100) == 99) begin
                vectors++;
                if (update_o !== 1'b1 || count_o !== want || valid_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL continuous_counts cyc=%0d got upd=%b cnt=%h vld=%b want upd=1 cnt=%h vld=1",
                             k, update_o, count_o, valid_o, want);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int want;
`ifdef TURF_RATE_MONITOR_SATURATE_EN
        want = 255;
`else
        want = 44;
`endif
        do_reset();
        gate_len_i = 16'd299; oneshot_i = 1'b0; run_i = 1'b1;
        step();
        for (int k = 0; k < 300; k++) begin
            evt_i = {NCH-1'(($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000), 1'b1};
            evt_i[3:1] = 3'($urandom) & 3'($urandom);
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL overflow cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (update_o !== 1'b1 || count_o[7:0] !== 8'(want) || ovf_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL overflow_latched got upd=%b cnt0=%0d ovf=%b want upd=1 cnt0=%0d ovf=0001",
                     update_o, count_o[7:0], ovf_o, want);
        end
    endtask

    task automatic test_oneshot();
        int ups = 0;
        do_reset();
        gate_len_i = 16'd9; oneshot_i = 1'b1; run_i = 1'b1; evt_i = 4'b0001;
        step();
        for (int k = 0; k < 30; k++) begin
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL oneshot cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            if (update_o === 1'b1) begin
                ups++;
                vectors++;
                if (count_o[7:0] !== 8'd10) begin
                    miscompares++;
                    $display("FAIL oneshot_count got=%0d want=10", count_o[7:0]);
                end
            end
        end
        vectors++;
        if (ups != 1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_single got ups=%0d busy=%b want ups=1 busy=0", ups, busy_o);
        end
        run_i = 1'b0;
        step();
        run_i = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL oneshot_rearm cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            if (update_o === 1'b1) ups++;
        end
        vectors++;
        if (ups != 2) begin
            miscompares++;
            $display("FAIL oneshot_second got ups=%0d want=2", ups);
        end
    endtask

    task automatic test_abort();
        logic [NCH*CW-1:0] saved;
        do_reset();
        gate_len_i = 16'd99; oneshot_i = 1'b0; run_i = 1'b1;
        step();
        for (int k = 0; k <= 150; k++) begin
            evt_i = {3'($urandom), 1'b1};
            run_i = (k != 150);
            step();
            if (k == 99) saved = m_count;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (update_o !== 1'b0 || count_o !== saved || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_hold got upd=%b cnt=%h busy=%b want upd=0 cnt=%h busy=0",
                     update_o, count_o, busy_o, saved);
        end
        run_i = 1'b1;
        step();
        for (int k = 0; k < 100; k++) begin
            evt_i = {3'($urandom), 1'b1};
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort_restart cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (update_o !== 1'b1 || count_o[7:0] !== 8'd100) begin
            miscompares++;
            $display("FAIL abort_fresh got upd=%b cnt0=%0d want upd=1 cnt0=100", update_o, count_o[7:0]);
        end
    endtask

    task automatic test_gate_reload();
        int ups[$];
        int want[3] = '{99, 109, 119};
        do_reset();
        gate_len_i = 16'd99; oneshot_i = 1'b0; run_i = 1'b1;
        step();
        for (int k = 0; k < 120; k++) begin
            if (k == 40) gate_len_i = 16'd9;
            evt_i = NCH'($urandom);
            step();
            if (update_o === 1'b1) ups.push_back(k);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL gate_reload cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (ups.size() != 3 || ups[0] != want[0] || ups[1] != want[1] || ups[2] != want[2]) begin
            miscompares++;
            $display("FAIL gate_reload_timing got n=%0d first=%0d want n=3 at 99/109/119",
                     ups.size(), (ups.size() > 0) ? ups[0] : -1);
        end
    endtask

    task automatic test_gate_zero();
        logic [NCH-1:0]    e;
        logic [NCH*CW-1:0] want;
        do_reset();
        gate_len_i = 16'd0; oneshot_i = 1'b0; run_i = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            e = NCH'($urandom);
            evt_i = e;
            step();
            for (int n = 0; n < NCH; n++) want[n*CW +: CW] = CW'(e[n]);
            vectors++;
            if (update_o !== 1'b1 || count_o !== want || dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL gate_zero cyc=%0d got upd=%b cnt=%h want upd=1 cnt=%h",
                         k, update_o, count_o, want);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        run_i = 1'b0; oneshot_i = 1'b0; gate_len_i = '0;
        for (int k = 0; k < 2000; k++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) run_i = ~run_i;
            if ($urandom_range(0, 49) == 0) oneshot_i = ~oneshot_i;
            gate_len_i = GW'($urandom_range(0, 7));
            evt_i = NCH'($urandom);
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; run_i = 1'b0; oneshot_i = 1'b0; evt_i = '0; gate_len_i = '0;
        @(negedge clk_i);
        test_reset();
        test_continuous();
        test_overflow();
        test_oneshot();
        test_abort();
        test_gate_reload();
        test_gate_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
